addsub_serial: RTL and testbench

ADDSUB_SERIAL -- requirements
Module: addsub_serial

---
 rtl/addsub_serial.sv | 121 ++++++++++++
 tb/tb_addsub_serial.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/addsub_serial.sv
// Chunk-serial two's complement adder/subtractor: one CHUNK-wide slice per clock, LSB first.
// Optional macro ADDSUB_SAT_EN saturates z on signed overflow.
module addsub_serial #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z,
  output logic             carry,
  output logic             ovf,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Handshake: start is taken on any edge where busy=0 (IDLE or DONE); x, y
  // and op are captured on that edge. done is a one-cycle valid for z/carry/ovf,
  // which then hold until the next completion. start while busy is ignored.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] ye_r;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             c_r;
  logic             x_sign;
  logic             ye_sign;

  logic             accept;
  logic             last_slice;
  logic [CHUNK:0]   slice;
  logic [WIDTH+CHUNK-1:0] acc_cat;
  logic [WIDTH-1:0] sum_full;
  logic             ovf_nxt;

  assign accept     = start && (state != CALC);
  assign last_slice = (state == CALC) && (cnt == CW'(N - 1));
  assign busy       = (state == CALC);
  assign done       = (state == DONE);
  assign dbg_state  = state;

  assign slice    = {1'b0, x_r[CHUNK-1:0]} + {1'b0, ye_r[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_r};
  // New slice enters at the top; after N slices the first one reaches bit 0.
  assign acc_cat  = {slice[CHUNK-1:0], acc};
  assign sum_full = acc_cat[WIDTH+CHUNK-1:CHUNK];
  assign ovf_nxt  = (x_sign == ye_sign) && (sum_full[WIDTH-1] != x_sign);

`ifdef ADDSUB_SAT_EN
  logic [WIDTH-1:0] sat_val;
  assign sat_val = x_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_slice) state_nxt = DONE;
      DONE:    state_nxt = start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_r     <= '0;
      ye_r    <= '0;
      acc     <= '0;
      cnt     <= '0;
      c_r     <= 1'b0;
      x_sign  <= 1'b0;
      ye_sign <= 1'b0;
      z       <= '0;
      carry   <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      x_r     <= x;
      ye_r    <= y ^ {WIDTH{op}};
      acc     <= '0;
      cnt     <= '0;
      c_r     <= op;
      x_sign  <= x[WIDTH-1];
      ye_sign <= y[WIDTH-1] ^ op;
    end else if (state == CALC) begin
      x_r  <= x_r >> CHUNK;
      ye_r <= ye_r >> CHUNK;
      acc  <= sum_full;
      cnt  <= cnt + CW'(1);
      c_r  <= slice[CHUNK];
      if (last_slice) begin
        carry <= slice[CHUNK];
        ovf   <= ovf_nxt;
`ifdef ADDSUB_SAT_EN
        z     <= ovf_nxt ? sat_val : sum_full;
`else
        z     <= sum_full;
`endif
      end
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial (WIDTH=64, CHUNK=16): expected results queued
// by the driver, popped and compared by a monitor on every done pulse.
module tb_addsub_serial;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic [W-1:0] z;
  logic         carry, ovf, busy, done;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [W+1:0] exp_q[$];

  addsub_serial #(.WIDTH(64), .CHUNK(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .x(x), .y(y),
    .z(z), .carry(carry), .ovf(ovf), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        check("z", z, e[W+1:2]);
        check("carry", {63'd0, carry}, {63'd0, e[1]});
        check("ovf", {63'd0, ovf}, {63'd0, e[0]});
      end
    end
  end

  // driver: issue one op, measure busy cycles and start-to-done latency
  task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ez, input logic ec, input logic eo);
    int cycles, busy_cnt;
    exp_q.push_back({ez, ec, eo});
    @(negedge clk);
    start = 1'b1; op = o; x = a; y = b;
    cycles = 0; busy_cnt = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cycles++;
      if (busy) busy_cnt++;
    end while (!done && cycles < 20);
    check("latency", 64'(cycles - 1), 64'd4);
    check("busy_cycles", 64'(busy_cnt), 64'd4);
  endtask

  initial begin
    logic [W-1:0] pos_z, neg_z;
    int cycles, done_cnt;
`ifdef ADDSUB_SAT_EN
    pos_z = 64'h7FFF_FFFF_FFFF_FFFF;
    neg_z = 64'h8000_0000_0000_0000;
`else
    pos_z = 64'h8000_0000_0000_0000;
    neg_z = 64'h7FFF_FFFF_FFFF_FFFF;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_z", z, 64'd0);
    check("rst_carry", {63'd0, carry}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    rst = 1'b0;

    run_op(1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'h0000_0001_0000_0000, 1'b0, 1'b0);
    run_op(1'b1, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op(1'b1, 64'd5, 64'd3, 64'd2, 1'b1, 1'b0);
    run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
    run_op(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, pos_z, 1'b0, 1'b1);
    run_op(1'b1, 64'h8000_0000_0000_0000, 64'd1, neg_z, 1'b1, 1'b1);

    // start pulsed at CALC cycle 2 must not disturb the running op
    exp_q.push_back({64'd3, 1'b0, 1'b0});
    @(negedge clk);
    start = 1'b1; op = 1'b0; x = 64'd1; y = 64'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 1'b1; x = 64'd100; y = 64'd100;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    check("ignored_start_done_seen", {63'd0, done}, 64'd1);

    // reset at CALC cycle 2 aborts with no done pulse
    @(negedge clk);
    start = 1'b1; op = 1'b0; x = 64'd7; y = 64'd9;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_z", z, 64'd0);
    check("abort_carry", {63'd0, carry}, 64'd0);
    check("abort_ovf", {63'd0, ovf}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_state", {62'd0, dbg_state}, 64'd0);
    done_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);

    // back-to-back: start held high through the first done cycle
    exp_q.push_back({64'd30, 1'b0, 1'b0});
    exp_q.push_back({64'd42, 1'b1, 1'b0});
    @(negedge clk);
    start = 1'b1; op = 1'b0; x = 64'd10; y = 64'd20;
    @(negedge clk);
    op = 1'b1; x = 64'd50; y = 64'd8;
    cycles = 1;
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    check("b2b_first_latency", 64'(cycles - 1), 64'd4);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy_rise", {63'd0, busy}, 64'd1);
    cycles = 1;
    while (!done && cycles < 20) begin
      check("b2b_z_hold", z, 64'd30);
      @(negedge clk);
      cycles++;
    end
    check("b2b_second_latency", 64'(cycles - 1), 64'd4);

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
